// File: rtl/arb_req_pkg.sv
// Shared types and helpers for the arbiter request front end.
package arb_req_pkg;

    localparam int unsigned AGE_W   = 8;
    localparam int unsigned MAX_REQ = 32;

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } state_e;

    // Bit offset of priority matrix entry (i,j).
    function automatic int unsigned pm_idx(input int unsigned i, input int unsigned j,
                                           input int unsigned n, input int unsigned pw);
        return (i * n + j) * pw;
    endfunction

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic int unsigned lowest_idx(input logic [MAX_REQ-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int unsigned k = MAX_REQ; k > 0; k--) begin
            if (v[k-1]) idx = k - 1;
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_req_front_if.sv
// Client command, arbiter and transfer signals of the request front end.
interface arb_req_front_if #(
    parameter int unsigned NUM_REQUESTORS = 4,
    parameter int unsigned PRIORITY_WIDTH = 2,
    parameter int unsigned LEN_WIDTH      = 4
);
    logic [NUM_REQUESTORS-1:0]                               cli_valid;
    logic [NUM_REQUESTORS*LEN_WIDTH-1:0]                     cli_len;
    logic [NUM_REQUESTORS-1:0]                               cli_ready;
    logic [NUM_REQUESTORS-1:0]                               req;
    logic [NUM_REQUESTORS*NUM_REQUESTORS*PRIORITY_WIDTH-1:0] priority_matrix;
    logic [NUM_REQUESTORS-1:0]                               grant;
    logic                                                    grant_valid;
    logic                                                    xfer_ready;
    logic                                                    xfer_active;
    logic [NUM_REQUESTORS-1:0]                               xfer_owner;
    logic                                                    xfer_beat;
    logic                                                    xfer_last;
    logic [NUM_REQUESTORS-1:0]                               done;

    modport slave (
        input  cli_valid, cli_len, grant, grant_valid, xfer_ready,
        output cli_ready, req, priority_matrix, xfer_active, xfer_owner, xfer_beat,
        xfer_last, done
    );

    modport master (
        output cli_valid, cli_len, grant, grant_valid, xfer_ready,
        input  cli_ready, req, priority_matrix, xfer_active, xfer_owner, xfer_beat,
        xfer_last, done
    );
endinterface

// File: rtl/arb_req_slot.sv
// One client's command slot: pending flag, remaining beats and, with
// ARB_REQ_AGING_EN, a saturating wait age mapped to a priority level.
module arb_req_slot
    import arb_req_pkg::*;
#(
`ifdef ARB_REQ_AGING_EN
    parameter int unsigned PRIORITY_WIDTH = 2,
    parameter int unsigned AGE_SHIFT      = 2,
`endif
    parameter int unsigned LEN_WIDTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_accept,
    input  logic [LEN_WIDTH-1:0]      i_len,
    input  logic                      i_win,
    input  logic                      i_owner,
    input  logic                      i_beat,
    output logic                      o_pending,
    output logic                      o_pending_next,
`ifdef ARB_REQ_AGING_EN
    output logic [PRIORITY_WIDTH-1:0] o_prio,
`endif
    output logic [LEN_WIDTH-1:0]      o_beats_left
);
    logic                 r_pending;
    logic [LEN_WIDTH-1:0] r_beats_left;
    logic                 w_clear;

    always_comb begin
        w_clear        = i_beat & (r_beats_left == '0);
        o_pending_next = i_accept | (r_pending & ~w_clear);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending    <= 1'b0;
            r_beats_left <= '0;
        end else begin
            r_pending <= o_pending_next;
            if (i_accept) begin
                r_beats_left <= i_len;
            end else if (i_beat && (r_beats_left != '0)) begin
                r_beats_left <= r_beats_left - 1'b1;
            end
        end
    end

    assign o_pending    = r_pending;
    assign o_beats_left = r_beats_left;

`ifdef ARB_REQ_AGING_EN
    localparam logic [AGE_W-1:0] PRIO_MAX = AGE_W'((1 << PRIORITY_WIDTH) - 1);

    logic [AGE_W-1:0] r_age;
    logic [AGE_W-1:0] w_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_age <= '0;
        end else if (i_accept || i_win) begin
            r_age <= '0;
        end else if (r_pending && !i_owner && !(&r_age)) begin
            r_age <= r_age + 1'b1;
        end
    end

    always_comb begin
        w_level = r_age >> AGE_SHIFT;
        o_prio  = (w_level > PRIO_MAX) ? PRIO_MAX[PRIORITY_WIDTH-1:0]
                                       : w_level[PRIORITY_WIDTH-1:0];
    end
`endif

endmodule

// File: rtl/arb_req_front.sv
// Requestor front end for the matrix arbiter: per-client command slots, request
// and priority-matrix registers, and a burst engine. Aging via ARB_REQ_AGING_EN.
module arb_req_front
    import arb_req_pkg::*;
#(
    parameter int unsigned NUM_REQUESTORS = 4,
    parameter int unsigned PRIORITY_WIDTH = 2,
    parameter int unsigned LEN_WIDTH      = 4,
    parameter int unsigned AGE_SHIFT      = 2
) (
    input logic            clk,
    input logic            rst,
    arb_req_front_if.slave bus
);
    localparam int unsigned N    = NUM_REQUESTORS;
    localparam int unsigned PM_W = N * N * PRIORITY_WIDTH;

`ifdef ARB_REQ_AGING_EN
    localparam logic [PM_W-1:0] PM_RESET = '0;
`else
    function automatic logic [PM_W-1:0] static_pm();
        logic [PM_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (i < j) m[pm_idx(i, j, N, PRIORITY_WIDTH) +: PRIORITY_WIDTH] = PRIORITY_WIDTH'(1);
            end
        end
        return m;
    endfunction

    localparam logic [PM_W-1:0] PM_RESET = static_pm();
`endif

    state_e               r_state;
    state_e               w_state_next;
    logic [N-1:0]         r_owner;
    logic [N-1:0]         r_req;
    logic [N-1:0]         r_done;
    logic [PM_W-1:0]      r_pm;
    logic [N-1:0]         w_owner_next;
    logic [N-1:0]         w_cand;
    logic [N-1:0]         w_pick;
    logic [N-1:0]         w_pending;
    logic [N-1:0]         w_pending_next;
    logic [LEN_WIDTH-1:0] w_beats_left [N];
    logic [LEN_WIDTH-1:0] w_owner_left;
    logic [PM_W-1:0]      w_pm_next;
    logic                 w_start;
    logic                 w_active;
    logic                 w_beat;
    logic                 w_last;
    logic                 w_end;
`ifdef ARB_REQ_AGING_EN
    logic [PRIORITY_WIDTH-1:0] w_prio [N];
`endif

    for (genvar i = 0; i < N; i++) begin : g_slot
        arb_req_slot #(
`ifdef ARB_REQ_AGING_EN
            .PRIORITY_WIDTH (PRIORITY_WIDTH),
            .AGE_SHIFT      (AGE_SHIFT),
`endif
            .LEN_WIDTH      (LEN_WIDTH)
        ) u_slot (
            .clk            (clk),
            .rst            (rst),
            .i_accept       (bus.cli_valid[i] & ~w_pending[i]),
            .i_len          (bus.cli_len[i*LEN_WIDTH +: LEN_WIDTH]),
            .i_win          (w_start & w_pick[i]),
            .i_owner        (r_owner[i]),
            .i_beat         (w_beat & r_owner[i]),
            .o_pending      (w_pending[i]),
            .o_pending_next (w_pending_next[i]),
`ifdef ARB_REQ_AGING_EN
            .o_prio         (w_prio[i]),
`endif
            .o_beats_left   (w_beats_left[i])
        );
    end

    // Grants arriving during a burst or for empty slots are ignored.
    always_comb begin
        w_cand  = bus.grant & w_pending & ~r_owner;
        w_pick  = N'(1) << lowest_idx(MAX_REQ'(w_cand));
        w_start = (r_state == StIdle) & bus.grant_valid & (|w_cand);
        w_owner_left = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (r_owner[i]) w_owner_left = w_owner_left | w_beats_left[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_start) w_state_next = StBurst;
            StBurst: if (w_end)   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_active = (r_state == StBurst);
        w_beat   = w_active & bus.xfer_ready;
        w_last   = w_active & (w_owner_left == '0);
        w_end    = w_beat & w_last;
        bus.xfer_active = w_active;
        bus.xfer_beat   = w_beat;
        bus.xfer_last   = w_last;
    end

    always_comb begin
        if (w_start)    w_owner_next = w_pick;
        else if (w_end) w_owner_next = '0;
        else            w_owner_next = r_owner;
    end

`ifdef ARB_REQ_AGING_EN
    always_comb begin
        w_pm_next = '0;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (i != j) w_pm_next[pm_idx(i, j, N, PRIORITY_WIDTH) +: PRIORITY_WIDTH] = w_prio[i];
            end
        end
    end
`else
    assign w_pm_next = PM_RESET;
`endif

    // The owner's request drops on the same edge its grant is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= '0;
            r_req   <= '0;
            r_done  <= '0;
            r_pm    <= PM_RESET;
        end else begin
            r_owner <= w_owner_next;
            r_req   <= w_pending_next & ~w_owner_next;
            r_done  <= w_end ? r_owner : '0;
            r_pm    <= w_pm_next;
        end
    end

    assign bus.cli_ready       = ~w_pending;
    assign bus.req             = r_req;
    assign bus.priority_matrix = r_pm;
    assign bus.xfer_owner      = r_owner;
    assign bus.done            = r_done;

endmodule

// File: doc/arb_req_front.md
# arb_req_front

Requestor-side front end for the matrix arbiter. Accepts one burst command per client through a valid/ready handshake and drives the arbiter's `req` vector and `priority_matrix`. It consumes the arbiter's registered `grant` and runs the granted client's burst beat by beat on a shared transfer port. Optional aging raises the priority of long-waiting clients so they cannot starve.

## Interface
- `NUM_REQUESTORS`, 4: number of clients; must match the arbiter.
- `PRIORITY_WIDTH`, 2: width of each priority matrix entry.
- `LEN_WIDTH`, 4: burst length field width; a burst is `len+1` beats.
- `AGE_SHIFT`, 2: age-to-priority divisor, as log2.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `cli_valid` in N: per-client command valid.
- `cli_len` in N*LEN_WIDTH: per-client burst length minus one. Client i uses `[i*LEN_WIDTH +: LEN_WIDTH]`.
- `cli_ready` out N: slot i is empty and can accept a command.
- `req` out N: registered request vector to the arbiter.
- `priority_matrix` out N*N*PRIORITY_WIDTH: registered. Entry (i,j) is at `(i*N+j)*PRIORITY_WIDTH`.
- `grant` in N: arbiter grant; may be multi-hot.
- `grant_valid` in 1: OR of `grant`.
- `xfer_ready` in 1: downstream accepts a beat this cycle.
- `xfer_active` out 1: a burst is in progress.
- `xfer_owner` out N: one-hot owner of the current burst; zero when idle.
- `xfer_beat` out 1: a beat transfers this cycle; equals `xfer_active & xfer_ready`.
- `xfer_last` out 1: the current beat is the burst's final beat.
- `done` out N: registered one-cycle pulse on the owner bit, the cycle after the last beat.

## Operation
- **Per-client slot** holds three fields: `pending`, `beats_left` (`LEN_WIDTH` bits) and `age`.
  - `cli_ready[i] = ~pending[i]`.
  - On `cli_valid[i] & cli_ready[i]`: `pending[i]` is set, `beats_left = cli_len[i]`, `age = 0`.
- **Request register:** `req <= pending_next & ~owner_next`. The owner's request drops when it takes its grant.
- **Engine FSM:**
  - IDLE:
    - Compute `cand = grant & pending & ~xfer_owner`.
    - If `grant_valid` and `cand` is non-zero, latch owner = lowest set bit of `cand` and go to BURST.
    - Otherwise stay in IDLE. Grant bits with no matching pending slot are ignored.
  - BURST:
    - Each `xfer_beat` decrements the owner's `beats_left`.
    - `xfer_last = xfer_active & (beats_left == 0)`.
    - On `xfer_beat & xfer_last`: clear the owner's `pending`, schedule `done[owner]`, clear the owner, go to IDLE.
    - All `grant` activity is ignored while in BURST.
- **Multi-hot grants:** the arbiter emits a multi-hot grant when priorities tie. The lowest index always wins here; the other bits remain pending.
- **Zero-length command:** `len=0` gives a single-beat burst. `xfer_last` is high in the first BURST cycle.
- **Aging** (only with the macro): `age[i]` increments by 1 each cycle that `pending[i]` is set and i is not the owner. It saturates at all-ones, 8 bits wide, and is cleared when i wins a grant.

## Timing
- Reset values:
  - `cli_ready` = all ones.
  - `req`, `xfer_owner`, `done` = 0.
  - `priority_matrix` = static value (see Configuration).
  - `xfer_active`, `xfer_beat`, `xfer_last` = 0.
  - FSM in IDLE; all ages 0.
- Command accepted at edge t: `req[i]` is high in cycle t+1 and the arbiter grant is visible in t+2.
- Grant sampled at the end of t+2: BURST from t+3. First beat possible at t+3.
- Minimum burst duration is `len+1` cycles with `xfer_ready` held high. `done` pulses in the cycle after the last beat.
- `cli_ready[i]` returns high the cycle after the last beat. A new command can then be accepted and requested again.
- A new burst can start one cycle after the last beat (return through IDLE). Back-to-back throughput is therefore at most `len+1` beats per `len+2` cycles.
- `priority_matrix` updates one cycle after the age change.
- Reset mid-burst drops the burst and clears all slots immediately, asynchronously. No `done` pulse is emitted.

## Configuration
- `ARB_REQ_AGING_EN`, **defined**:
  - Entry (i,j) for i≠j = `min(age[i] >> AGE_SHIFT, 2^PRIORITY_WIDTH-1)`. Diagonal entries are 0.
  - After reset all entries are 0, so ties are resolved by the lowest-index rule.
- `ARB_REQ_AGING_EN`, **undefined**:
  - No age counters.
  - Static strict order: entry (i,j) = 1 if i<j, else 0. The lowest index wins.

## Structure
- Package `arb_req_pkg`:
  - FSM state enum (IDLE, BURST).
  - Matrix-index helper function.
  - Age width constant (8).
  - Lowest-set-bit function.
- One sub-module `arb_req_slot`, instantiated N times. It holds `pending`, `beats_left` and `age`, and computes its priority level.

## Test plan
1. Client 2 sends `len=3`; `xfer_ready` is held high → `req=0100` at t+1, BURST at t+3, four beats, `xfer_last` on the fourth beat, `done=0100` the next cycle.
2. Clients 0 and 3 request together (aging off) → client 0 completes first; client 3 starts two cycles after client 0's last beat.
3. Tied multi-hot `grant=1010` with pending `1010` (aging on, ages 0) → owner is `0010`; client 3 stays pending.
4. Client 1 waits 12 cycles behind a long burst from client 0 (aging on, shift 2) → row 1 entries read 3 and client 1 wins over fresh client 0.
5. `xfer_ready` toggled 1,0,1,0 during a `len=1` burst → beats land only on ready cycles; `done` follows the second accepted beat.
6. `rst` asserted in the middle of a burst → all outputs return to reset values in the same cycle; a command issued after release is accepted normally.
